// File: rtl/lf_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch path.
// Imported by the fetch sequencer and its output buffer.
package lf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam logic [31:0] PC_STEP           = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO that absorbs the instruction memory read latency.
// Flush empties it in one cycle and overrides push and pop.
module fetch_skid_buffer
    import lf_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head,
    output logic         head_valid
);

    fetch_entry_t entries [2];
    logic         rd_ptr;
    logic         wr_ptr;

    // NOTE: the storage is reset too, so the head reads as zero out of reset
    // instead of X; with only two entries the extra reset fan-out is trivial.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entries[0] <= '0;
            entries[1] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_entry;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head       = entries[rd_ptr];
    assign head_valid = (count != 2'd0);

endmodule

// File: rtl/fetch_sequencer.sv
// LEGv8 fetch controller: owns the PC, issues word reads to a one-cycle
// instruction memory and hands instructions to decode over valid/ready.
module fetch_sequencer
    import lf_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_enable,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_instruction,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic        halted
);

    localparam logic [2:0] BUF_LIMIT = 3'(BUF_DEPTH);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc;
    logic [31:0]  req_pc;
    logic         inflight;
    logic         req_epoch;
    logic         epoch;

    logic         pop;
    logic         returned;
    logic         push;
    logic         halt_hit;
    logic         issue;
    logic [1:0]   buf_count;
    logic [2:0]   occupancy;
    fetch_entry_t head;
    fetch_entry_t push_entry;

    assign pop      = instr_valid & instr_ready;
    // A word tagged with an old epoch belongs to a path abandoned by a redirect or halt.
    assign returned = inflight && (req_epoch == epoch);
    assign push     = returned && !branch_taken;
    assign halt_hit = (state == FETCH) && push && (imem_instruction == HALT_WORD);

    // Reserve a slot for every word already buffered or on its way back.
    assign occupancy = {1'b0, buf_count} + {2'b00, inflight};
    assign issue     = (state == FETCH) && fetch_enable && !branch_taken
                       && (occupancy < (BUF_LIMIT + {2'b00, pop}));

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave state_next unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!branch_taken && fetch_enable) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (!fetch_enable) begin
                    state_next = IDLE;
                end else if (halt_hit) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                if (branch_taken) begin
                    state_next = fetch_enable ? FETCH : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            req_pc    <= 32'd0;
            inflight  <= 1'b0;
            req_epoch <= 1'b0;
            epoch     <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= issue;
            if (issue) begin
                req_pc    <= pc;
                req_epoch <= epoch;
            end
            if (branch_taken) begin
                pc <= branch_target & ~32'd3;
            end else if (issue) begin
                pc <= pc + PC_STEP;
            end
            if (branch_taken || halt_hit) begin
                epoch <= ~epoch;
            end
        end
    end

    assign push_entry = '{instr: imem_instruction, pc: req_pc};

    fetch_skid_buffer u_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop & ~branch_taken),
        .flush      (branch_taken),
        .count      (buf_count),
        .head       (head),
        .head_valid (instr_valid)
    );

    assign imem_address = {2'b00, pc[31:2]};
    assign instr_data   = head.instr;
    assign instr_pc     = head.pc;
    assign halted       = (state == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a one-cycle memory model returns
// word n as n+100, and every accepted instruction is matched in order.
module tb_fetch_sequencer;
    import lf_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_enable;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        halted;

    int           checks   = 0;
    int           failures = 0;
    bit           halt_mode = 1'b0;
    fetch_entry_t exp_q[$];
    fetch_entry_t mon_e;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_enable     (fetch_enable),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr_data       (instr_data),
        .instr_pc         (instr_pc),
        .halted           (halted)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] waddr);
        if (halt_mode && waddr == 32'd3) return 32'hFFFF_FFFF;
        return waddr + 32'd100;
    endfunction

    // Clocked instruction memory with one cycle of read latency.
    always @(posedge clk) imem_instruction <= mem_word(imem_address);

    // Scoreboard consumer and occupancy watch, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (dut.u_buf.count > 2'd2) begin
                failures++;
                $display("FAIL buf_overflow: count=%0d required<=2", dut.u_buf.count);
            end
            if (instr_valid && instr_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_instr: pc=%h data=%h required none", instr_pc, instr_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (instr_pc !== mon_e.pc || instr_data !== mon_e.instr) begin
                        failures++;
                        $display("FAIL accept_order: pc=%h data=%h required pc=%h data=%h",
                                 instr_pc, instr_data, mon_e.pc, mon_e.instr);
                    end
                end
            end
        end
    end

    task automatic expect_seq(input logic [31:0] start_pc, input int n);
        fetch_entry_t e;
        for (int i = 0; i < n; i++) begin
            e.pc    = start_pc + 32'(4 * i);
            e.instr = mem_word(e.pc >> 2);
            exp_q.push_back(e);
        end
    endtask

    // Counts rising edges until the scoreboard empties; ends 1 time unit after an edge.
    task automatic wait_drain(output int n);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d words outstanding required 0", exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks += 5;
        if (instr_valid !== 1'b0) begin failures++; $display("FAIL %s_valid: got %b required 0", tag, instr_valid); end
        if (instr_data !== 32'd0) begin failures++; $display("FAIL %s_data: got %h required 0", tag, instr_data); end
        if (instr_pc !== 32'd0) begin failures++; $display("FAIL %s_pc: got %h required 0", tag, instr_pc); end
        if (halted !== 1'b0) begin failures++; $display("FAIL %s_halted: got %b required 0", tag, halted); end
        if (imem_address !== 32'd0) begin failures++; $display("FAIL %s_addr: got %h required 0", tag, imem_address); end
    endtask

    task automatic test_reset;
        reset = 1'b1; fetch_enable = 1'b0; branch_taken = 1'b0;
        branch_target = 32'd0; instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_stream;
        int n;
        expect_seq(32'h0, 2);
        fetch_enable = 1'b1;
        instr_ready  = 1'b1;
        wait_drain(n);
        checks++;
        if (n !== 5) begin failures++; $display("FAIL stream_timing: edges=%0d required 5", n); end
        instr_ready = 1'b0;
    endtask

    task automatic test_stall;
        int n;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'h8 || instr_data !== 32'd102) begin
                failures++;
                $display("FAIL stall_head: valid=%b pc=%h data=%h required 1/8/102", instr_valid, instr_pc, instr_data);
            end
        end
        checks++;
        if (imem_address !== 32'd4) begin failures++; $display("FAIL stall_addr: got %h required 4", imem_address); end
        @(posedge clk); #1;
        expect_seq(32'h8, 4);
        instr_ready = 1'b1;
        wait_drain(n);
        checks++;
        if (n !== 4) begin failures++; $display("FAIL stall_release: edges=%0d required 4", n); end
    endtask

    task automatic test_redirect;
        int n;
        instr_ready   = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h43;
        @(posedge clk); #1;
        branch_taken = 1'b0;
        @(negedge clk);
        checks += 2;
        if (instr_valid !== 1'b0) begin failures++; $display("FAIL redirect_flush: valid=%b required 0", instr_valid); end
        if (imem_address !== 32'h10) begin failures++; $display("FAIL redirect_addr: got %h required 10", imem_address); end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0) begin failures++; $display("FAIL redirect_gap: valid=%b required 0", instr_valid); end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr_data !== 32'd116) begin
            failures++;
            $display("FAIL redirect_target: valid=%b pc=%h data=%h required 1/40/116", instr_valid, instr_pc, instr_data);
        end
        @(negedge clk);
        checks++;
        if (imem_address !== 32'h12) begin failures++; $display("FAIL redirect_fill: addr=%h required 12", imem_address); end
        @(posedge clk); #1;
        expect_seq(32'h40, 4);
        instr_ready = 1'b1;
        wait_drain(n);
        checks++;
        if (n !== 4) begin failures++; $display("FAIL redirect_release: edges=%0d required 4", n); end
    endtask

    task automatic test_enable_drop;
        int n;
        expect_seq(32'h50, 2);
        fetch_enable = 1'b0;
        wait_drain(n);
        checks++;
        if (n !== 2) begin failures++; $display("FAIL disable_tail: edges=%0d required 2", n); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b0 || imem_address !== 32'h16) begin
                failures++;
                $display("FAIL disable_idle: valid=%b addr=%h required 0/16", instr_valid, imem_address);
            end
        end
        @(posedge clk); #1;
        expect_seq(32'h58, 4);
        fetch_enable = 1'b1;
        wait_drain(n);
        checks++;
        if (n !== 7) begin failures++; $display("FAIL reenable: edges=%0d required 7", n); end
    endtask

    task automatic test_halt;
        int n;
        instr_ready   = 1'b0;
        halt_mode     = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h0;
        @(posedge clk); #1;
        branch_taken = 1'b0;
        expect_seq(32'h0, 4);
        instr_ready = 1'b1;
        wait_drain(n);
        checks++;
        if (n !== 6) begin failures++; $display("FAIL halt_stream: edges=%0d required 6", n); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (halted !== 1'b1 || instr_valid !== 1'b0 || imem_address !== 32'd5) begin
                failures++;
                $display("FAIL halt_state: halted=%b valid=%b addr=%h required 1/0/5", halted, instr_valid, imem_address);
            end
        end
        @(posedge clk); #1;
        halt_mode     = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h0;
        @(posedge clk); #1;
        branch_taken = 1'b0;
        expect_seq(32'h0, 4);
        wait_drain(n);
        checks += 2;
        if (n !== 6) begin failures++; $display("FAIL halt_resume: edges=%0d required 6", n); end
        if (halted !== 1'b0) begin failures++; $display("FAIL halt_clear: halted=%b required 0", halted); end
        instr_ready = 1'b0;
    endtask

    task automatic test_async_reset;
        repeat (3) @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h10 || instr_data !== 32'd104) begin
            failures++;
            $display("FAIL prereset_head: valid=%b pc=%h data=%h required 1/10/104", instr_valid, instr_pc, instr_data);
        end
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        fetch_enable = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_enable_drop();
        test_halt();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
